instruction_sequencer: RTL and testbench

Cycle-level sequencer for the CPU core. It steps every instruction through FETCH, DECODE, address-phase and operation-phase cycles, using the cycle counts the opcode decoder produces. It inserts the 7-cycle interrupt/reset entry sequence and stalls on memory not-ready. Its phase and timeStep outputs drive the per-phase control-flag ROMs.

---
 rtl/instruction_sequencer.sv | 121 ++++++++++++
 tb/tb_instruction_sequencer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: steps each instruction through FETCH/DECODE/ADDR/OP,
// inserts the interrupt/reset entry sequence and freezes on memory not-ready.
module instruction_sequencer #(
   parameter int INT_CYCLES = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ready,
   input  logic [2:0] addressTimingCode,
   input  logic [2:0] opTimingCode,
   input  logic       pageCross,
   input  logic       irqReq,
   input  logic       nmiReq,
   input  logic       iFlag,
   output logic [2:0] phase,
   output logic [2:0] timeStep,
   output logic       loadOpcode,
   output logic       instrDone,
   output logic       intActive,
   output logic [1:0] vectorSel
);
   typedef enum logic [2:0] {
      P_FETCH  = 3'd0,
      P_DECODE = 3'd1,
      P_ADDR   = 3'd2,
      P_OP     = 3'd3,
      P_INT    = 3'd4
   } phase_e;

   phase_e     phase_q, phase_d;
   logic [2:0] ts_q, ts_d, addr_len_q, addr_len_d, op_len_q, op_len_d;
   logic [1:0] vsel_q, vsel_d;
   logic       cross_q, cross_d, nmi_pend_q, nmi_pend_d, nmi_prev_q;
   logic       nmi_edge, take_nmi, take_irq, last_nominal, extend, addr_end, done;

   always_comb begin
      nmi_edge     = nmiReq & ~nmi_prev_q;
      take_nmi     = nmi_pend_q | nmi_edge;
      take_irq     = irqReq & ~iFlag;
      last_nominal = ts_q == addr_len_q - 3'd1;
      extend       = phase_q == P_ADDR && last_nominal && pageCross && !cross_q;
      // once the page-cross cycle is used, the phase ends one step later
      addr_end     = cross_q ? ts_q == addr_len_q : last_nominal && !pageCross;
      done         = ready && (phase_q == P_DECODE ? addressTimingCode == 3'd0 && opTimingCode == 3'd0 :
                               phase_q == P_ADDR   ? addr_end && op_len_q == 3'd0 :
                               phase_q == P_OP     ? ts_q == op_len_q - 3'd1 : 1'b0);
      phase_d    = phase_q;
      ts_d       = ts_q;
      addr_len_d = addr_len_q;
      op_len_d   = op_len_q;
      cross_d    = cross_q;
      vsel_d     = vsel_q;
      nmi_pend_d = nmi_pend_q | nmi_edge;
      if (ready) begin
         ts_d = ts_q + 3'd1;
         case (phase_q)
            P_FETCH: begin
               phase_d = P_DECODE;
               ts_d    = 3'd0;
            end
            P_DECODE: begin
               addr_len_d = addressTimingCode;
               op_len_d   = opTimingCode;
               cross_d    = 1'b0;
               phase_d    = addressTimingCode != 3'd0 ? P_ADDR : P_OP;
               ts_d       = 3'd0;
            end
            P_ADDR: begin
               if (extend) cross_d = 1'b1;
               else if (addr_end) begin
                  phase_d = P_OP;
                  ts_d    = 3'd0;
               end
            end
            P_INT: begin
               if (ts_q == 3'(INT_CYCLES - 1)) begin
                  phase_d = P_FETCH;
                  ts_d    = 3'd0;
                  vsel_d  = 2'd0;
               end
            end
            default: ;
         endcase
         if (done) begin
            ts_d    = 3'd0;
            phase_d = take_nmi || take_irq ? P_INT : P_FETCH;
            vsel_d  = take_nmi ? 2'd1 : take_irq ? 2'd3 : 2'd0;
            if (take_nmi) nmi_pend_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q    <= P_INT;
         ts_q       <= 3'd0;
         addr_len_q <= 3'd0;
         op_len_q   <= 3'd0;
         cross_q    <= 1'b0;
         vsel_q     <= 2'd2;
         nmi_pend_q <= 1'b0;
         nmi_prev_q <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         ts_q       <= ts_d;
         addr_len_q <= addr_len_d;
         op_len_q   <= op_len_d;
         cross_q    <= cross_d;
         vsel_q     <= vsel_d;
         nmi_pend_q <= nmi_pend_d;
         nmi_prev_q <= nmiReq;
      end
   end

   assign phase      = phase_q;
   assign timeStep   = ts_q;
   assign loadOpcode = ready && phase_q == P_FETCH;
   assign instrDone  = done;
   assign intActive  = phase_q == P_INT;
   assign vectorSel  = vsel_q;
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: per-cycle vector table checked mid-cycle against the sequencer
module tb_instruction_sequencer;
  localparam int F = 0, D = 1, A = 2, O = 3, I = 4;
  typedef struct {
    logic        rs, rd, pc, iq, nm, fl;
    logic [2:0]  a, o;
    logic [10:0] exp;
  } vec_t;
  logic       clk = 1'b0, rst = 1'b1, ready = 1'b1;
  logic [2:0] addressTimingCode = '0, opTimingCode = '0;
  logic       pageCross = 1'b0, irqReq = 1'b0, nmiReq = 1'b0, iFlag = 1'b1;
  logic [2:0] phase, timeStep;
  logic       loadOpcode, instrDone, intActive;
  logic [1:0] vectorSel;
  vec_t        tbl[$];
  logic [10:0] exp_q[$];
  int          errors = 0, checks = 0;
  logic        finished = 1'b0;
  instruction_sequencer #(.INT_CYCLES(7)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .addressTimingCode(addressTimingCode), .opTimingCode(opTimingCode),
    .pageCross(pageCross), .irqReq(irqReq), .nmiReq(nmiReq), .iFlag(iFlag),
    .phase(phase), .timeStep(timeStep), .loadOpcode(loadOpcode),
    .instrDone(instrDone), .intActive(intActive), .vectorSel(vectorSel)
  );
  always #5 clk = ~clk;
  function automatic void add(int rs, int rd, int a, int o, int pc, int iq, int nm, int fl,
                              int ph, int ts, int ld, int dn, int ia, int vs);
    vec_t v;
    v.rs = 1'(rs); v.rd = 1'(rd); v.a = 3'(a); v.o = 3'(o);
    v.pc = 1'(pc); v.iq = 1'(iq); v.nm = 1'(nm); v.fl = 1'(fl);
    v.exp = {3'(ph), 3'(ts), 1'(ld), 1'(dn), 1'(ia), 2'(vs)};
    tbl.push_back(v);
  endfunction
  function automatic void int_run(int vs);
    for (int k = 1; k < 7; k++) add(0,1,0,0,0,0,0,1, I,k,0,0,1,vs);
  endfunction
  task automatic check(input logic [10:0] e, input string tag);
    logic [10:0] got;
    got = {phase, timeStep, loadOpcode, instrDone, intActive, vectorSel};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got ph=%0d ts=%0d ld=%b dn=%b ia=%b vs=%0d, want ph=%0d ts=%0d ld=%b dn=%b ia=%b vs=%0d",
               tag, got[10:8], got[7:5], got[4], got[3], got[2], got[1:0],
               e[10:8], e[7:5], e[4], e[3], e[2], e[1:0]);
    end
  endtask
  initial begin
    #100000;
    if (!finished) begin
      errors++;
      $display("FAIL timeout: bench did not finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end
  initial begin
    add(1,1,0,0,0,0,0,1, I,0,0,0,1,2);
    add(0,1,0,0,0,0,0,1, I,0,0,0,1,2); int_run(2);
    add(0,1,0,0,0,0,0,1, F,0,1,0,0,0);
    add(0,1,2,3,0,0,0,1, D,0,0,0,0,0);
    add(0,1,0,0,0,0,0,1, A,0,0,0,0,0);
    add(0,1,0,0,0,0,0,1, A,1,0,0,0,0);
    add(0,1,0,0,0,0,0,1, O,0,0,0,0,0);
    add(0,1,0,0,0,0,0,1, O,1,0,0,0,0);
    add(0,1,0,0,0,0,0,1, O,2,0,1,0,0);
    add(0,1,0,0,0,0,0,1, F,0,1,0,0,0);
    add(0,1,0,0,0,0,0,1, D,0,0,1,0,0);
    add(0,1,0,0,0,0,0,1, F,0,1,0,0,0);
    add(0,1,2,1,0,0,0,1, D,0,0,0,0,0);
    add(0,1,0,0,1,0,0,1, A,0,0,0,0,0);
    add(0,1,0,0,1,0,0,1, A,1,0,0,0,0);
    add(0,1,0,0,1,0,0,1, A,2,0,0,0,0);
    add(0,1,0,0,0,0,0,1, O,0,0,1,0,0);
    add(0,1,0,0,0,1,0,1, F,0,1,0,0,0);
    add(0,1,0,0,0,1,0,1, D,0,0,1,0,0);
    add(0,1,0,0,0,1,0,0, F,0,1,0,0,0);
    add(0,1,0,0,0,1,0,0, D,0,0,1,0,0);
    add(0,1,0,0,0,0,0,1, I,0,0,0,1,3); int_run(3);
    add(0,1,0,0,0,1,1,0, F,0,1,0,0,0);
    add(0,1,0,0,0,1,0,0, D,0,0,1,0,0);
    add(0,1,0,0,0,0,0,1, I,0,0,0,1,1); int_run(1);
    add(0,1,0,0,0,1,0,0, F,0,1,0,0,0);
    add(0,1,0,0,0,1,0,0, D,0,0,1,0,0);
    add(0,1,0,0,0,0,0,1, I,0,0,0,1,3); int_run(3);
    add(0,1,0,0,0,0,0,1, F,0,1,0,0,0);
    add(0,1,0,0,0,0,1,1, D,0,0,1,0,0);
    add(0,1,0,0,0,0,1,1, I,0,0,0,1,1); int_run(1);
    add(0,1,0,0,0,0,0,1, F,0,1,0,0,0);
    add(0,1,0,0,0,0,0,1, D,0,0,1,0,0);
    add(0,1,0,0,0,0,0,1, F,0,1,0,0,0);
    add(0,1,2,1,0,0,0,1, D,0,0,0,0,0);
    add(0,1,0,0,0,0,0,1, A,0,0,0,0,0);
    add(0,0,0,0,0,0,0,1, A,1,0,0,0,0);
    add(0,0,0,0,0,0,1,1, A,1,0,0,0,0);
    add(0,0,0,0,0,0,0,1, A,1,0,0,0,0);
    add(0,1,0,0,0,0,0,1, A,1,0,0,0,0);
    add(0,1,0,0,0,0,0,1, O,0,0,1,0,0);
    add(0,1,0,0,0,0,0,1, I,0,0,0,1,1); int_run(1);
    add(0,0,0,0,0,0,0,1, F,0,0,0,0,0);
    add(0,1,0,0,0,0,0,1, F,0,1,0,0,0);
    add(0,0,0,0,0,0,0,1, D,0,0,0,0,0);
    add(0,1,0,0,0,0,0,1, D,0,0,1,0,0);
    add(0,1,0,0,0,0,0,1, F,0,1,0,0,0);
    add(0,1,1,3,0,0,1,1, D,0,0,0,0,0);
    add(0,1,0,0,0,0,0,1, A,0,0,0,0,0);
    add(0,1,0,0,0,0,0,1, O,0,0,0,0,0);
    add(1,1,0,0,0,0,0,1, O,1,0,0,0,0);
    add(0,1,0,0,0,0,0,1, I,0,0,0,1,2); int_run(2);
    add(0,1,0,0,0,0,0,1, F,0,1,0,0,0);
    add(0,1,0,0,0,0,0,1, D,0,0,1,0,0);
    add(0,1,0,0,0,0,0,1, F,0,1,0,0,0);
    repeat (2) @(posedge clk);
    #1;
    check({3'(I), 3'd0, 1'b0, 1'b0, 1'b1, 2'd2}, "reset");
    foreach (tbl[n]) begin
      rst = tbl[n].rs; ready = tbl[n].rd;
      addressTimingCode = tbl[n].a; opTimingCode = tbl[n].o;
      pageCross = tbl[n].pc; irqReq = tbl[n].iq; nmiReq = tbl[n].nm; iFlag = tbl[n].fl;
      exp_q.push_back(tbl[n].exp);
      @(negedge clk);
      check(exp_q.pop_front(), $sformatf("row%0d", n));
      @(posedge clk);
      #1;
    end
    finished = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
